// File: rtl/clock_strobe_pkg.sv
// Shared definitions for the clock strobe generator.
//   DEF_*            default parameter values for clock_strobe_gen / strobe_acc
//   inc_arr_t        increment array type at the default channel count and width
//   lock_cnt_width() width of the lock counter for a given lock length
package clock_strobe_pkg;

    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_ACC_WIDTH   = 16;
    localparam int DEF_LOCK_CYCLES = 16;

    typedef logic [DEF_CHANNELS-1:0][DEF_ACC_WIDTH-1:0] inc_arr_t;

    // The counter has to hold the value LOCK_CYCLES itself, hence the +1.
    function automatic int lock_cnt_width(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/strobe_acc.sv
// One strobe channel: registered increment, phase accumulator and the
// registered carry-out that forms the one-cycle strobe.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   en_i    run enable
//   load_i  capture inc_i and restart the accumulator from zero
//   inc_i   phase increment, sampled only while load_i is high
//   stb_o   one-cycle strobe, high the cycle after the accumulator wraps
module strobe_acc
    import clock_strobe_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [ACC_WIDTH-1:0] inc_i,
    output logic                 stb_o
);

    logic [ACC_WIDTH-1:0] inc_q, inc_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 stb_q, stb_d;
    logic [ACC_WIDTH:0]   sum;

    // The extra top bit of the sum is the wrap carry that becomes the strobe.
    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
        inc_d = inc_q;
        acc_d = acc_q;
        stb_d = 1'b0;
        if (load_i) begin
            inc_d = inc_i;
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum[ACC_WIDTH-1:0];
            stb_d = sum[ACC_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inc_q <= '0;
            acc_q <= '0;
            stb_q <= 1'b0;
        end else begin
            inc_q <= inc_d;
            acc_q <= acc_d;
            stb_q <= stb_d;
        end
    end

    assign stb_o = stb_q;

endmodule

// File: rtl/clock_strobe_gen.sv
// Multi-channel fractional clock-enable generator. Each channel produces a
// strobe at mean rate f_clk * inc / 2^ACC_WIDTH; a shared lock counter
// reports when the strobes have run from a stable configuration for
// LOCK_CYCLES enabled cycles.
//   clk     clock
//   rst_n   asynchronous active-low reset
//   en      run enable for all channels
//   load    capture inc, clear accumulators and lock state
//   inc     per-channel phase increments (packed, channel 0 in the low word)
//   stb     per-channel one-cycle strobes
//   locked  high once LOCK_CYCLES enabled cycles have elapsed since load/enable
module clock_strobe_gen
    import clock_strobe_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                load,
    input  logic [CHANNELS-1:0][ACC_WIDTH-1:0]  inc,
    output logic [CHANNELS-1:0]                 stb,
    output logic                                locked
);

    localparam int               LCW      = lock_cnt_width(LOCK_CYCLES);
    localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CYCLES);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        strobe_acc #(
            .ACC_WIDTH (ACC_WIDTH)
        ) u_acc (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .en_i   (en),
            .load_i (load),
            .inc_i  (inc[g]),
            .stb_o  (stb[g])
        );
    end

    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           locked_q, locked_d;

    // Any load or paused cycle restarts the lock interval.
    always_comb begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
        if (!load && en) begin
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
            locked_d   = (lock_cnt_d == LOCK_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_clock_strobe_gen.sv
module tb_clock_strobe_gen;
    import clock_strobe_pkg::*;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int LK = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    inc_arr_t      inc;
    logic [CH-1:0] stb;
    logic          locked;

    int checks   = 0;
    int failures = 0;

    // Reference model: strobe k (k = enabled edges since load) occurs when
    // floor(k*inc/2^W) steps up; locked once LK enabled edges have elapsed
    // since the last load / pause / reset.
    longint unsigned m_inc [CH];
    longint unsigned m_k;
    int              m_run;
    logic [CH-1:0]   exp_stb;
    logic            exp_locked;

    clock_strobe_gen #(
        .CHANNELS    (CH),
        .ACC_WIDTH   (W),
        .LOCK_CYCLES (LK)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .inc    (inc),
        .stb    (stb),
        .locked (locked)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) m_inc[c] = 0;
        m_k        = 0;
        m_run      = 0;
        exp_stb    = '0;
        exp_locked = 1'b0;
    endtask

    // Drive one clock cycle of stimulus, advance the model, sample at edge+1.
    task automatic cycle(input logic e, input logic l, input inc_arr_t v);
        en   = e;
        load = l;
        inc  = v;
        @(posedge clk);
        if (l) begin
            for (int c = 0; c < CH; c++) m_inc[c] = longint'(v[c]);
            m_k        = 0;
            m_run      = 0;
            exp_stb    = '0;
            exp_locked = 1'b0;
        end else if (e) begin
            m_k++;
            m_run++;
            for (int c = 0; c < CH; c++)
                exp_stb[c] = ((m_k * m_inc[c]) >> W) != (((m_k - 1) * m_inc[c]) >> W);
            exp_locked = (m_run >= LK);
        end else begin
            exp_stb    = '0;
            m_run      = 0;
            exp_locked = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        inc   = '0;
        model_reset();
        #1;
        checks++;
        if (stb !== '0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_state stb=%b locked=%b exp stb=00 locked=0", stb, locked);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // No load yet: the registered increments are zero.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, inc_arr_t'({16'hFFFF, 16'hFFFF}));
            checks++;
            if (stb !== '0 || locked !== exp_locked) begin
                failures++;
                $display("FAIL reset_no_load i=%0d stb=%b locked=%b exp stb=00 locked=%b",
                         i, stb, locked, exp_locked);
            end
        end
        // Run with activity, then drop reset between edges.
        cycle(1'b0, 1'b1, inc_arr_t'({16'h8000, 16'h8000}));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stb !== '0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_async stb=%b locked=%b exp stb=00 locked=0 (before drop stb=%b locked=%b)",
                     stb, locked, exp_stb, exp_locked);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (stb !== '0) begin
                failures++;
                $display("FAIL reset_release i=%0d stb=%b exp=00", i, stb);
            end
        end
    endtask

    task automatic test_rates();
        cycle(1'b0, 1'b1, inc_arr_t'({16'h4000, 16'h8000}));
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (stb[0] !== (k % 2 == 0) || stb[1] !== (k % 4 == 0) || stb !== exp_stb) begin
                failures++;
                $display("FAIL rates k=%0d stb=%b exp=%b%b", k, stb, (k % 4 == 0), (k % 2 == 0));
            end
        end
    endtask

    task automatic test_extremes();
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;
        cycle(1'b0, 1'b1, inc_arr_t'({16'h0000, 16'h0000}));
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 1'b0, '0);
            if (stb[0]) n0++;
            if (stb[1]) n1++;
        end
        checks++;
        if (n0 != 0 || n1 != 0) begin
            failures++;
            $display("FAIL extreme_zero strobes ch0=%0d ch1=%0d exp 0", n0, n1);
        end
        n0 = 0;
        n1 = 0;
        cycle(1'b0, 1'b1, inc_arr_t'({16'h0000, 16'hFFFF}));
        for (int i = 0; i < 65536; i++) begin
            cycle(1'b1, 1'b0, '0);
            if (stb[0]) n0++;
            if (stb[1]) n1++;
        end
        checks++;
        if (n0 != 65535 || n1 != 0) begin
            failures++;
            $display("FAIL extreme_max strobes ch0=%0d ch1=%0d exp ch0=65535 ch1=0", n0, n1);
        end
    endtask

    task automatic test_lock();
        cycle(1'b0, 1'b1, inc_arr_t'({16'h1234, 16'h0F0F}));
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (locked !== (k >= LK)) begin
                failures++;
                $display("FAIL lock_rise k=%0d locked=%b exp=%b", k, locked, (k >= LK));
            end
        end
        cycle(1'b0, 1'b0, '0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_drop locked=%b exp=0", locked);
        end
        for (int k = 1; k <= 18; k++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (locked !== (k >= LK)) begin
                failures++;
                $display("FAIL lock_return k=%0d locked=%b exp=%b", k, locked, (k >= LK));
            end
        end
    endtask

    task automatic test_reload();
        cycle(1'b0, 1'b1, inc_arr_t'({16'hC000, 16'h8000}));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, inc_arr_t'({16'h2000, 16'h4000}));
        checks++;
        if (stb !== '0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reload_clear stb=%b locked=%b exp stb=00 locked=0", stb, locked);
        end
        for (int k = 1; k <= 24; k++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (stb[0] !== (k % 4 == 0) || stb[1] !== (k % 8 == 0) || locked !== exp_locked) begin
                failures++;
                $display("FAIL reload_rate k=%0d stb=%b locked=%b exp=%b%b locked=%b",
                         k, stb, locked, (k % 8 == 0), (k % 4 == 0), exp_locked);
            end
        end
        // Held load keeps clearing.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, inc_arr_t'({16'hFFFF, 16'hFFFF}));
            checks++;
            if (stb !== '0 || locked !== 1'b0) begin
                failures++;
                $display("FAIL reload_held i=%0d stb=%b locked=%b exp stb=00 locked=0", i, stb, locked);
            end
        end
    endtask

    task automatic test_pause();
        cycle(1'b0, 1'b1, inc_arr_t'({16'h5555, 16'h3000}));
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, '0);
            checks++;
            if (stb !== '0 || locked !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold i=%0d stb=%b locked=%b exp stb=00 locked=0", i, stb, locked);
            end
        end
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (stb !== exp_stb || locked !== exp_locked) begin
                failures++;
                $display("FAIL pause_resume i=%0d stb=%b locked=%b exp stb=%b locked=%b",
                         i, stb, locked, exp_stb, exp_locked);
            end
        end
    endtask

    task automatic test_random();
        inc_arr_t v;
        logic     e;
        logic     l;
        for (int i = 0; i < 2000; i++) begin
            v[0] = 16'($urandom);
            v[1] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            e    = ($urandom_range(0, 9) != 0);
            l    = ($urandom_range(0, 63) == 0);
            cycle(e, l, v);
            checks++;
            if (stb !== exp_stb || locked !== exp_locked) begin
                failures++;
                $display("FAIL random i=%0d stb=%b locked=%b exp stb=%b locked=%b",
                         i, stb, locked, exp_stb, exp_locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rates();
        test_extremes();
        test_lock();
        test_reload();
        test_pause();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_strobe_gen.md
CLOCK_STROBE_GEN -- requirements
Module: clock_strobe_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent strobe channels (1..8).
REQ-002 SHALL have parameter ACC_WIDTH, default 16: phase accumulator and increment width in bits (8..32).
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: enabled cycles after load/enable before locked asserts (>=1).
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1: run enable for all channels.
REQ-007 SHALL have port load, input, 1: single-cycle pulse capturing new increments.
REQ-008 SHALL have port inc, input, CHANNELS x ACC_WIDTH packed array: per-channel phase increment, sampled only when load=1.
REQ-009 SHALL have port stb, output, CHANNELS: per-channel one-cycle clock-enable strobe.
REQ-010 SHALL have port locked, output, 1: strobes are running from a stable configuration.

Function
REQ-011 SHALL hold, per channel, a registered increment inc_r[i] and accumulator acc[i], each ACC_WIDTH bits.
REQ-012 SHALL, on an edge with load=1 (regardless of en), capture inc into inc_r, clear every acc, drive stb to 0, clear the lock counter and drive locked to 0.
REQ-013 SHALL, on an edge with load=0 and en=1, set {carry_i, acc[i]} to acc[i] + inc_r[i] (ACC_WIDTH+1 bits) and register stb[i] <= carry_i.
REQ-014 SHALL therefore produce a mean strobe rate of f_clk * inc_r[i] / 2^ACC_WIDTH; stb appears the cycle after the wrapping edge (1-cycle latency).
REQ-015 SHALL, on an edge with load=0 and en=0, hold every acc, drive stb to 0, clear the lock counter and drive locked to 0.
REQ-016 SHALL never strobe a channel whose inc_r is 0; inc_r = 2^ACC_WIDTH-1 strobes on all but one cycle per 2^ACC_WIDTH.
REQ-017 SHALL keep a saturating lock counter, width clog2(LOCK_CYCLES+1), incremented on each edge with en=1 and load=0, saturating at LOCK_CYCLES.
REQ-018 SHALL register locked high on the edge where the counter reaches LOCK_CYCLES and keep it high until the next load, en=0 edge or reset.
REQ-019 SHALL treat channels independently; simultaneous wraps on several channels assert all corresponding stb bits in the same cycle.
REQ-020 SHALL not ignore a load asserted for several consecutive cycles; every such edge reloads and clears (load behaves as held clear).

Reset
REQ-021 SHALL, while rst_n=0 and without waiting for a clock edge, set inc_r=0, acc=0, stb=0, lock counter=0 and locked=0.
REQ-022 SHALL, after rst_n deasserts, produce no strobes until a load with a non-zero increment followed by en=1.

Structure
REQ-023 SHALL place default parameter values and the increment array typedef in shared package clock_strobe_pkg.
REQ-024 SHALL implement one channel (inc_r, acc, carry, stb register) as sub-module strobe_acc, instantiated CHANNELS times via generate; lock counter stays in the top.

Verification (CHANNELS=2, ACC_WIDTH=16, LOCK_CYCLES=16, 100 MHz clk)
REQ-025 SHALL check reset: drop rst_n mid-run between edges -> stb=0 and locked=0 immediately; no strobes after release until load.
REQ-026 SHALL check rates: load inc={0x4000,0x8000}, en=1 -> stb[0] every 2nd cycle with first strobe after 2nd enabled edge, stb[1] every 4th cycle with first after 4th edge.
REQ-027 SHALL check extremes: inc=0 -> zero strobes in 1000 cycles; inc=0xFFFF -> exactly 65535 strobes in 65536 enabled cycles.
REQ-028 SHALL check lock: locked rises exactly on the 16th enabled edge after load; a single en=0 cycle drops it, and it returns 16 enabled edges later.
REQ-029 SHALL check reload mid-run: load with en=1 -> stb=0 and locked=0 next cycle, acc restarts from 0, new rate applies from the following edge.
REQ-030 SHALL check pause: en=0 for 5 cycles -> stb held 0, acc frozen; resuming continues the strobe pattern without phase loss.
